// File: rtl/lfsr_period_ctrl_if.sv
// Request/result and LFSR-side signals of the LFSR period checker.
// master: the environment (requester plus LFSR under test); slave: the checker.
interface lfsr_period_ctrl_if #(
  parameter int unsigned W     = 16,
  parameter int unsigned CNT_W = W + 1
);
  logic             start;
  logic [W-1:0]     seed;
  logic             abort;
  logic [W-1:0]     lfsr_seed;
  logic             lfsr_load;
  logic [W-1:0]     lfsr_state;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] period;
  logic             max_len;
  logic             timeout;

  modport master (
    output start, seed, abort, lfsr_state,
    input  lfsr_seed, lfsr_load, busy, done, period, max_len, timeout
  );

  modport slave (
    input  start, seed, abort, lfsr_state,
    output lfsr_seed, lfsr_load, busy, done, period, max_len, timeout
  );
endinterface

// File: rtl/lfsr_period_ctrl.sv
// LFSR period checker: loads a seed into an external LFSR, free-runs it and
// counts steps until the state returns to the seed, or times out after 2^W.
module lfsr_period_ctrl #(
  parameter int unsigned W     = 16,
  parameter int unsigned CNT_W = W + 1
) (
  input  logic              clk,
  input  logic              reset,
  lfsr_period_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_e;

  localparam logic [CNT_W-1:0] CNT_ONE   = 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_ONE << W;
  localparam logic [CNT_W-1:0] MAX_P     = CNT_LIMIT - CNT_ONE;

  state_e           state_q, state_d;
  logic [W-1:0]     seed_q, seed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             max_len_q, max_len_d;
  logic             timeout_q, timeout_d;

  logic match;
  logic at_limit;

  // cnt==0 excluded so the freshly loaded seed in the first RUN cycle is not a hit
  assign match    = (cnt_q != '0) && (bus.lfsr_state == seed_q);
  assign at_limit = (cnt_q == CNT_LIMIT);

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      seed_q    <= '0;
      cnt_q     <= '0;
      period_q  <= '0;
      max_len_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      seed_q    <= seed_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      max_len_q <= max_len_d;
      timeout_q <= timeout_d;
    end
  end

  // Next state and datapath updates; abort outranks match, match outranks timeout
  always_comb begin
    state_d   = state_q;
    seed_d    = seed_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    max_len_d = max_len_q;
    timeout_d = timeout_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          seed_d    = bus.seed;
          cnt_d     = '0;
          period_d  = '0;
          max_len_d = 1'b0;
          timeout_d = 1'b0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: state_d = S_RUN;
      S_RUN: begin
        if (bus.abort) begin
          period_d  = '0;
          max_len_d = 1'b0;
          timeout_d = 1'b0;
          state_d   = S_DONE;
        end else if (match) begin
          period_d  = cnt_q;
          max_len_d = (cnt_q == MAX_P);
          state_d   = S_DONE;
        end else if (at_limit) begin
          period_d  = '0;
          max_len_d = 1'b0;
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; results come straight from their registers
  always_comb begin
    bus.lfsr_seed = seed_q;
    bus.lfsr_load = (state_q == S_LOAD);
    bus.busy      = (state_q == S_LOAD) || (state_q == S_RUN);
    bus.done      = (state_q == S_DONE);
    bus.period    = period_q;
    bus.max_len   = max_len_q;
    bus.timeout   = timeout_q;
  end

endmodule

// File: tb/tb_lfsr_period_ctrl.sv
// Directed bench for lfsr_period_ctrl: a W=16 instance for the full-length and
// short cases, and a W=8 instance for ignored start, reset and timeout.
module tb_lfsr_period_ctrl;

  logic clk = 1'b0;
  logic rst16 = 1'b0;
  logic rst8  = 1'b0;
  logic stub8 = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int n;

  always #5 clk = ~clk;

  lfsr_period_ctrl_if #(.W(16)) if16 ();
  lfsr_period_ctrl_if #(.W(8))  if8  ();

  lfsr_period_ctrl #(.W(16)) dut16 (.clk(clk), .reset(rst16), .bus(if16));
  lfsr_period_ctrl #(.W(8))  dut8  (.clk(clk), .reset(rst8),  .bus(if8));

  // Maximal Fibonacci LFSRs with synchronous load: x^16+x^14+x^13+x^11+1, x^8+x^6+x^5+x^4+1
  logic [15:0] l16_q = '0;
  logic [7:0]  l8_q  = '0;

  always @(posedge clk)
    l16_q <= if16.lfsr_load ? if16.lfsr_seed
                            : {l16_q[14:0], l16_q[15] ^ l16_q[13] ^ l16_q[12] ^ l16_q[10]};

  // stub8 turns the 8-bit LFSR into a tail: seed once, then 8'hFF forever
  always @(posedge clk)
    l8_q <= if8.lfsr_load ? if8.lfsr_seed
          : stub8         ? 8'hFF
                          : {l8_q[6:0], l8_q[7] ^ l8_q[5] ^ l8_q[4] ^ l8_q[3]};

  assign if16.lfsr_state = l16_q;
  assign if8.lfsr_state  = l8_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // n counts edges with the accepting start edge as 1
  task automatic wait16(input int limit);
    while (!if16.done && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic wait8(input int limit);
    while (!if8.done && n < limit) begin
      tick();
      n++;
    end
  endtask

  initial begin
    if16.start = 1'b0; if16.seed = '0; if16.abort = 1'b0;
    if8.start  = 1'b0; if8.seed  = '0; if8.abort  = 1'b0;
    tick(); tick();

    // Reset values
    check("rst16_busy",    {31'd0, if16.busy},      32'd0);
    check("rst16_done",    {31'd0, if16.done},      32'd0);
    check("rst16_load",    {31'd0, if16.lfsr_load}, 32'd0);
    check("rst16_period",  {15'd0, if16.period},    32'd0);
    check("rst16_seed",    {16'd0, if16.lfsr_seed}, 32'd0);
    check("rst16_max",     {31'd0, if16.max_len},   32'd0);
    check("rst8_timeout",  {31'd0, if8.timeout},    32'd0);
    rst16 = 1'b1;
    rst8  = 1'b1;
    tick();

    // Maximal 16-bit run from seed 0001
    if16.seed = 16'h0001; if16.start = 1'b1;
    tick(); n = 1;
    if16.start = 1'b0;
    check("t1_load_on",  {31'd0, if16.lfsr_load}, 32'd1);
    check("t1_busy",     {31'd0, if16.busy},      32'd1);
    tick(); n = 2;
    check("t1_load_off", {31'd0, if16.lfsr_load}, 32'd0);
    wait16(70000);
    check("t1_latency",  n,                       32'd65538);
    check("t1_period",   {15'd0, if16.period},    32'd65535);
    check("t1_max",      {31'd0, if16.max_len},   32'd1);
    check("t1_timeout",  {31'd0, if16.timeout},   32'd0);
    check("t1_busy_dn",  {31'd0, if16.busy},      32'd0);
    tick();
    check("t1_done_pulse", {31'd0, if16.done},    32'd0);
    check("t1_hold",     {15'd0, if16.period},    32'd65535);

    // Lock-up seed 0000: period 1
    if16.seed = 16'h0000; if16.start = 1'b1;
    tick(); n = 1;
    if16.start = 1'b0;
    wait16(100);
    check("t2_latency",  n,                       32'd4);
    check("t2_period",   {15'd0, if16.period},    32'd1);
    check("t2_max",      {31'd0, if16.max_len},   32'd0);
    check("t2_timeout",  {31'd0, if16.timeout},   32'd0);
    tick();

    // Abort at RUN cnt=100
    if16.seed = 16'hACE1; if16.start = 1'b1;
    tick();
    if16.start = 1'b0;
    tick();
    for (int i = 0; i < 100; i++) tick();
    check("t3_busy_run", {31'd0, if16.busy},      32'd1);
    if16.abort = 1'b1;
    tick();
    if16.abort = 1'b0;
    check("t3_done",     {31'd0, if16.done},      32'd1);
    check("t3_period",   {15'd0, if16.period},    32'd0);
    check("t3_max",      {31'd0, if16.max_len},   32'd0);
    check("t3_timeout",  {31'd0, if16.timeout},   32'd0);
    check("t3_busy",     {31'd0, if16.busy},      32'd0);
    check("t3_seed",     {16'd0, if16.lfsr_seed}, 32'h0000ACE1);
    tick();

    // Second start during RUN is ignored (8-bit, maximal period 255)
    if8.seed = 8'h5A; if8.start = 1'b1;
    tick(); n = 1;
    if8.start = 1'b0;
    tick(); n = 2;
    for (int i = 0; i < 50; i++) begin tick(); n++; end
    if8.seed = 8'h33; if8.start = 1'b1;
    tick(); n++;
    if8.start = 1'b0;
    check("t4_seed_kept", {24'd0, if8.lfsr_seed}, 32'h5A);
    wait8(600);
    check("t4_latency",  n,                       32'd258);
    check("t4_period",   {23'd0, if8.period},     32'd255);
    check("t4_max",      {31'd0, if8.max_len},    32'd1);
    tick();
    check("t4_no_queue", {31'd0, if8.busy},       32'd0);

    // Reset mid-RUN, then a clean measurement
    if8.seed = 8'h01; if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    for (int i = 0; i < 101; i++) tick();
    check("t5_busy_pre", {31'd0, if8.busy},       32'd1);
    rst8 = 1'b0;
    #1;
    check("t5_busy",     {31'd0, if8.busy},       32'd0);
    check("t5_done",     {31'd0, if8.done},       32'd0);
    check("t5_period",   {23'd0, if8.period},     32'd0);
    check("t5_seed",     {24'd0, if8.lfsr_seed},  32'd0);
    tick();
    check("t5_no_done",  {31'd0, if8.done},       32'd0);
    rst8 = 1'b1;
    tick();
    if8.seed = 8'h01; if8.start = 1'b1;
    tick(); n = 1;
    if8.start = 1'b0;
    wait8(600);
    check("t5_latency",  n,                       32'd258);
    check("t5_period2",  {23'd0, if8.period},     32'd255);
    check("t5_max",      {31'd0, if8.max_len},    32'd1);
    tick();

    // Tail LFSR never revisits the seed: timeout after 2^W steps
    stub8 = 1'b1;
    if8.seed = 8'h01; if8.start = 1'b1;
    tick(); n = 1;
    if8.start = 1'b0;
    wait8(600);
    check("t6_latency",  n,                       32'd259);
    check("t6_timeout",  {31'd0, if8.timeout},    32'd1);
    check("t6_period",   {23'd0, if8.period},     32'd0);
    check("t6_max",      {31'd0, if8.max_len},    32'd0);
    tick();
    check("t6_hold",     {31'd0, if8.timeout},    32'd1);
    stub8 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lfsr_period_ctrl.md
Name: lfsr_period_ctrl

Overview:
- Sequencer wrapped around the 16-bit LFSR (lfsr16-style: seed input, synchronous load on active-high load/reset input, next-state output).
- On request, loads a seed into the LFSR and free-runs it one step per clock.
- Counts steps until the LFSR state returns to the seed, then reports the period and whether it is maximal (2^W-1).
- Replaces hand-written bench checking with a reusable hardware period checker for any LFSR variant the team builds.

Parameters:
- W, 16, LFSR state width; seed, state and period widths derive from it.
- CNT_W, W+1, step-counter width; must hold 2^W for timeout detection.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- seed  input  W  seed to test; captured on accepted start.
- abort  input  1  synchronous abort of a running measurement.
- lfsr_seed  output  W  seed driven to the LFSR.
- lfsr_load  output  1  active-high load strobe to the LFSR's reset/load input.
- lfsr_state  input  W  current LFSR output.
- busy  output  1  high in LOAD and RUN.
- done  output  1  one-cycle pulse when a result is valid.
- period  output  CNT_W  measured period; 0 on timeout or abort.
- max_len  output  1  period == 2^W-1.
- timeout  output  1  state did not return to the seed within 2^W steps.

Behaviour:
- Reset (reset low, async): state=IDLE; seed_reg, cnt, lfsr_seed, period = 0; lfsr_load, busy, done, max_len, timeout = 0.
- Reset low mid-RUN abandons the measurement immediately; no done pulse is generated.
- IDLE:
  - start=1 captures seed into seed_reg, clears cnt, period, max_len and timeout, then goes to LOAD.
  - start while busy or in DONE is ignored; no queuing.
- LOAD (1 cycle):
  - lfsr_load=1; lfsr_seed=seed_reg (lfsr_seed tracks seed_reg in all states).
  - The LFSR presents the seed on lfsr_state in the following cycle.
  - Next state: RUN.
- RUN:
  - lfsr_load=0. The first RUN cycle has cnt=0 with lfsr_state==seed_reg.
  - Each cycle evaluate in priority order:
    - abort=1: DONE with period=0, timeout=0, max_len=0.
    - cnt!=0 and lfsr_state==seed_reg: DONE with period=cnt, max_len=(cnt==2^W-1).
    - cnt==2^W: DONE with timeout=1, period=0, max_len=0.
    - otherwise cnt <= cnt+1.
  - The seed is compared against lfsr_state, not against a first-sampled state, so a seed that is never revisited (a tail into a cycle) yields timeout.
- DONE (1 cycle): done=1, busy=0; next state IDLE.
- Results hold until the next accepted start.
- Latency:
  - done is asserted 3+P cycles after the accepting start edge (start edge → LOAD → RUN first cycle → P further steps → DONE).
  - For a maximal 16-bit LFSR, P=65535.
- Lock-up seed (all-zero for XOR taps): the state repeats every step, giving period=1, max_len=0.
- cnt never wraps: CNT_W=W+1 guarantees that 2^W is representable.
- Simultaneous abort and match in the same cycle: abort wins.

Test Plan:
- seed=16'h0001, start pulse on a maximal-tap LFSR → lfsr_load high exactly 1 cycle; done after 65538 cycles; period=65535, max_len=1, timeout=0.
- seed=16'h0000 (XOR LFSR) → done at cycle 4; period=1, max_len=0.
- Start seed=16'hACE1; assert abort at RUN cycle 100 → done next cycle; period=0, max_len=0, timeout=0; busy low.
- Second start pulse at RUN cycle 50 with seed=16'h1234 → ignored; seed_reg remains the original; the original measurement completes with period=65535.
- Drop reset mid-RUN (cnt≈30000) → busy, done and period read 0 immediately; a new start seed=16'h0001 gives period=65535.
- Stub the LFSR with a model that never returns to the seed (tail state) → done with timeout=1, period=0 after 2^16+3 cycles.
